gcd_sequencer: RTL

- Clocked front-end stage that sits directly upstream of the combinational GCD block and downstream of it for capture.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives each pair onto the GCD block's X/Y/Reset inputs, waits a fixed settle time, captures gcd_output, and returns the result with its operands over a valid/ready handshake.
- Gives the purely combinational GCD a registered, flow-controlled interface for synchronous system logic.

---
 rtl/gcd_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gcd_sequencer
// Description : Valid/ready front-end for a combinational GCD block. Buffers
//               operand pairs, drives each one onto the GCD block, waits a
//               settle time, and returns the captured result with its operands.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_sequencer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    output logic [WIDTH-1:0]         gcd_x,
    output logic [WIDTH-1:0]         gcd_y,
    output logic                     gcd_reset,
    input  logic [WIDTH-1:0]         gcd_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_x,
    output logic [WIDTH-1:0]         out_y,
    output logic [WIDTH-1:0]         out_gcd,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_SETTLE_WAIT = 2'd1,
        S_HOLD        = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [2*WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    logic                   ready_en;
    logic [CW-1:0]          settle_cnt;

    logic                   push;
    logic                   pop;
    logic                   load;
    logic                   capture;
    logic                   release_out;
    logic                   fifo_empty;
    logic [2*WIDTH-1:0]     head;

    // ready_en keeps in_ready low until the first edge after reset release
    assign in_ready   = ready_en && (count < (AW+1)'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_x, in_y};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load        = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load       = 1'b1;
                    state_next = S_SETTLE_WAIT;
                end
            end
            S_SETTLE_WAIT: begin
                if (settle_cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    release_out = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        load       = 1'b1;
                        state_next = S_SETTLE_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_en   <= 1'b0;
            settle_cnt <= '0;
            gcd_x      <= '0;
            gcd_y      <= '0;
            gcd_reset  <= 1'b1;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_gcd    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            if (load) begin
                gcd_x      <= head[2*WIDTH-1:WIDTH];
                gcd_y      <= head[WIDTH-1:0];
                gcd_reset  <= 1'b0;
                settle_cnt <= CW'(SETTLE - 1);
            end else begin
                if (state == S_SETTLE_WAIT && settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
                // GCD block goes idle only when nothing follows the released result
                if (release_out) begin
                    gcd_reset <= 1'b1;
                end
            end

            if (capture) begin
                out_x     <= gcd_x;
                out_y     <= gcd_y;
                out_gcd   <= gcd_result;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
